target_tracker: RTL and testbench

- Frame-level multi-target tracker, the parametrised successor to the per-row marker target accumulator.
- Accepts per-row marker detections from the count_flips row detector stage through a valid/ready handshake, and clusters them into NUM_TARGETS slots using a distance gate.
- At frame end it commits a stable, double-buffered target table to downstream consumers (overlay, pose logic) and clears its working table.

---
 rtl/target_tracker_pkg.sv | 31 +++
 rtl/target_tracker_slot_select.sv | 56 +++++
 rtl/target_tracker.sv | 272 +++++++++++++++++++++++++++
 tb/tb_target_tracker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/target_tracker_pkg.sv
// target_pkg: shared types for the frame-level target tracker.
//   slot_t   - one working/committed target slot
//   state_t  - frame control FSM states
//   PKG_*    - field widths of slot_t, derived from the default screen size.
//              The tracker's parameters must keep XW/YW/SCORE_W/HIT_W equal
//              to these so the slot storage matches the port widths.
package target_pkg;

    localparam int SCREEN_WIDTH_DEF  = 1280;
    localparam int SCREEN_HEIGHT_DEF = 720;
    localparam int PKG_XW            = $clog2(SCREEN_WIDTH_DEF) + 1;
    localparam int PKG_YW            = $clog2(SCREEN_HEIGHT_DEF) + 1;
    localparam int PKG_SCORE_W       = 11;
    localparam int PKG_HIT_W         = 6;

    typedef struct packed {
        logic                   valid;
        logic [PKG_XW-1:0]      x;
        logic [PKG_YW-1:0]      y;
        logic [PKG_YW-1:0]      diam;
        logic [PKG_SCORE_W-1:0] score;
        logic [PKG_HIT_W-1:0]   hits;
    } slot_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/target_tracker_slot_select.sv
// slot_select: combinational slot priority logic for the tracker.
//   match_vec   in  per-slot "valid and inside gate"
//   free_vec    in  per-slot "slot unused"
//   score_vec   in  per-slot stored score
//   match_found/match_idx  out  lowest-index gated slot
//   free_found/free_idx    out  lowest-index free slot
//   worst_idx              out  highest score, lowest index on ties
module slot_select
    import target_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]                  match_vec,
    input  logic [N-1:0]                  free_vec,
    input  logic [N-1:0][PKG_SCORE_W-1:0] score_vec,
    output logic                          match_found,
    output logic [IW-1:0]                 match_idx,
    output logic                          free_found,
    output logic [IW-1:0]                 free_idx,
    output logic [IW-1:0]                 worst_idx
);

    logic [PKG_SCORE_W-1:0] worst_score;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
            if (free_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Strict compare keeps the earlier slot on equal scores.
    always_comb begin
        worst_idx   = '0;
        worst_score = score_vec[0];
        for (int i = 1; i < N; i++) begin
            if (score_vec[i] > worst_score) begin
                worst_score = score_vec[i];
                worst_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/target_tracker.sv
// target_tracker: clusters per-row marker detections into NUM_TARGETS slots
// using a squared-distance gate and commits a stable target table per frame.
//   clk_in, rst_in (async, active-high)
//   det_valid_in/det_ready_out  detection handshake
//   det_x_in/det_y_in/det_diam_in/det_score_in  detection fields
//   frame_end_in       one-cycle frame close pulse
//   xcount_out/ycount_out/diameter_out/hits_out/valid_out  committed table
//   frame_valid_out    high for the cycle the committed table is new
//   dropped_out        detections dropped in the last committed frame
//
// state   | meaning
// COLLECT | accepting detections, one in flight at a time
// DRAIN   | frame closed, waiting for the in-flight detection to land
// COMMIT  | committed table freshly loaded, working table already cleared
module target_tracker
    import target_pkg::*;
#(
    parameter int  NUM_TARGETS   = 4,
    parameter int  SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int  SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int  SCORE_W       = PKG_SCORE_W,
    parameter int  MIN_HITS      = 2,
    parameter int  HIT_W         = PKG_HIT_W,
    localparam int XW            = $clog2(SCREEN_WIDTH) + 1,
    localparam int YW            = $clog2(SCREEN_HEIGHT) + 1
)(
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              det_valid_in,
    output logic                              det_ready_out,
    input  logic [XW-1:0]                     det_x_in,
    input  logic [YW-1:0]                     det_y_in,
    input  logic [YW-1:0]                     det_diam_in,
    input  logic [SCORE_W-1:0]                det_score_in,
    input  logic                              frame_end_in,
    output logic [NUM_TARGETS-1:0][XW-1:0]    xcount_out,
    output logic [NUM_TARGETS-1:0][YW-1:0]    ycount_out,
    output logic [NUM_TARGETS-1:0][YW-1:0]    diameter_out,
    output logic [NUM_TARGETS-1:0][HIT_W-1:0] hits_out,
    output logic [NUM_TARGETS-1:0]            valid_out,
    output logic                              frame_valid_out,
    output logic [7:0]                        dropped_out
);

    localparam int IW = $clog2(NUM_TARGETS);
    localparam int DW = 2 * XW + 1;
    localparam logic [PKG_HIT_W-1:0] MIN_HITS_V = PKG_HIT_W'(MIN_HITS);
    localparam logic [PKG_HIT_W-1:0] HIT_MAX    = '1;

    state_t state_q, state_d;
    logic   commit_go;
    logic   accept;

    logic                              s1_valid_q, s1_valid_d;
    logic [XW-1:0]                     s1_x_q, s1_x_d;
    logic [YW-1:0]                     s1_y_q, s1_y_d;
    logic [YW-1:0]                     s1_diam_q, s1_diam_d;
    logic [SCORE_W-1:0]                s1_score_q, s1_score_d;
    logic [NUM_TARGETS-1:0][DW-1:0]    dist_q, dist_d;
    logic [DW-1:0]                     gate_q, gate_d;

    slot_t [NUM_TARGETS-1:0]           tbl_q, tbl_d;
    logic [7:0]                        drop_q, drop_d;

    logic [NUM_TARGETS-1:0][XW-1:0]    x_out_q, x_out_d;
    logic [NUM_TARGETS-1:0][YW-1:0]    y_out_q, y_out_d;
    logic [NUM_TARGETS-1:0][YW-1:0]    diam_out_q, diam_out_d;
    logic [NUM_TARGETS-1:0][HIT_W-1:0] hits_out_q, hits_out_d;
    logic [NUM_TARGETS-1:0]            valid_out_q, valid_out_d;
    logic [7:0]                        dropped_q, dropped_d;
    logic                              fv_q, fv_d;

    logic [NUM_TARGETS-1:0]                  match_vec;
    logic [NUM_TARGETS-1:0]                  free_vec;
    logic [NUM_TARGETS-1:0][PKG_SCORE_W-1:0] score_vec;
    logic                                    match_found;
    logic                                    free_found;
    logic [IW-1:0]                           match_idx;
    logic [IW-1:0]                           free_idx;
    logic [IW-1:0]                           worst_idx;
    slot_t                                   upd_slot;
    slot_t                                   new_slot;

    // Full-precision squared distance; absolute differences keep the
    // operands unsigned so the squares never wrap.
    function automatic logic [DW-1:0] dist_sq(
        input logic [XW-1:0] ax,
        input logic [XW-1:0] bx,
        input logic [YW-1:0] ay,
        input logic [YW-1:0] by
    );
        logic [XW-1:0]   dx;
        logic [YW-1:0]   dy;
        logic [2*XW-1:0] dx2;
        logic [2*YW-1:0] dy2;
        dx  = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy  = (ay >= by) ? (ay - by) : (by - ay);
        dx2 = (2*XW)'(dx) * (2*XW)'(dx);
        dy2 = (2*YW)'(dy) * (2*YW)'(dy);
        return DW'(dx2) + DW'(dy2);
    endfunction

    // Ready only when stage 2 is empty: caps throughput at one detection per
    // two cycles and guarantees the table seen at handshake is up to date.
    assign det_ready_out = !rst_in && (state_q == COLLECT) && !s1_valid_q;
    assign accept        = det_valid_in && det_ready_out;

    always_comb begin
        state_d   = state_q;
        commit_go = 1'b0;
        case (state_q)
            COLLECT: if (frame_end_in) state_d = DRAIN;
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d   = COMMIT;
                    commit_go = 1'b1;
                end
            end
            COMMIT:  state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Stage 1: capture the detection and its distances to the current table.
    always_comb begin
        s1_valid_d = accept;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_diam_d  = s1_diam_q;
        s1_score_d = s1_score_q;
        dist_d     = dist_q;
        gate_d     = gate_q;
        if (accept) begin
            s1_x_d     = det_x_in;
            s1_y_d     = det_y_in;
            s1_diam_d  = det_diam_in;
            s1_score_d = det_score_in;
            gate_d     = DW'((2*YW)'(det_diam_in) * (2*YW)'(det_diam_in));
            for (int i = 0; i < NUM_TARGETS; i++) begin
                dist_d[i] = dist_sq(det_x_in, tbl_q[i].x, det_y_in, tbl_q[i].y);
            end
        end
    end

    always_comb begin
        match_vec = '0;
        free_vec  = '0;
        score_vec = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            match_vec[i] = tbl_q[i].valid && (dist_q[i] <= gate_q);
            free_vec[i]  = !tbl_q[i].valid;
            score_vec[i] = tbl_q[i].score;
        end
    end

    slot_select #(
        .N (NUM_TARGETS)
    ) u_slot_select (
        .match_vec   (match_vec),
        .free_vec    (free_vec),
        .score_vec   (score_vec),
        .match_found (match_found),
        .match_idx   (match_idx),
        .free_found  (free_found),
        .free_idx    (free_idx),
        .worst_idx   (worst_idx)
    );

    // Stage 2: merge / allocate / evict / drop.
    always_comb begin
        tbl_d    = tbl_q;
        drop_d   = drop_q;
        new_slot = '{valid: 1'b1, x: s1_x_q, y: s1_y_q, diam: s1_diam_q,
                     score: s1_score_q, hits: PKG_HIT_W'(1)};
        upd_slot = tbl_q[match_idx];
        if (upd_slot.hits != HIT_MAX) begin
            upd_slot.hits = upd_slot.hits + PKG_HIT_W'(1);
        end
        // Only a strictly better score moves the slot; ties keep the old fix.
        if (s1_score_q < upd_slot.score) begin
            upd_slot.x     = s1_x_q;
            upd_slot.y     = s1_y_q;
            upd_slot.diam  = s1_diam_q;
            upd_slot.score = s1_score_q;
        end
        if (commit_go) begin
            tbl_d  = '0;
            drop_d = '0;
        end else if (s1_valid_q) begin
            if (match_found) begin
                tbl_d[match_idx] = upd_slot;
            end else if (free_found) begin
                tbl_d[free_idx] = new_slot;
            end else if (s1_score_q < tbl_q[worst_idx].score) begin
                tbl_d[worst_idx] = new_slot;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // The committed table loads on the edge entering COMMIT, so
    // frame_valid_out and the new data appear in the same cycle.
    always_comb begin
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        diam_out_d  = diam_out_q;
        hits_out_d  = hits_out_q;
        valid_out_d = valid_out_q;
        dropped_d   = dropped_q;
        fv_d        = commit_go;
        if (commit_go) begin
            dropped_d = drop_q;
            for (int i = 0; i < NUM_TARGETS; i++) begin
                x_out_d[i]     = tbl_q[i].x;
                y_out_d[i]     = tbl_q[i].y;
                diam_out_d[i]  = tbl_q[i].diam;
                hits_out_d[i]  = tbl_q[i].hits;
                valid_out_d[i] = tbl_q[i].valid && (tbl_q[i].hits >= MIN_HITS_V);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= COLLECT;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_diam_q   <= '0;
            s1_score_q  <= '0;
            dist_q      <= '0;
            gate_q      <= '0;
            tbl_q       <= '0;
            drop_q      <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            diam_out_q  <= '0;
            hits_out_q  <= '0;
            valid_out_q <= '0;
            dropped_q   <= '0;
            fv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_diam_q   <= s1_diam_d;
            s1_score_q  <= s1_score_d;
            dist_q      <= dist_d;
            gate_q      <= gate_d;
            tbl_q       <= tbl_d;
            drop_q      <= drop_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            diam_out_q  <= diam_out_d;
            hits_out_q  <= hits_out_d;
            valid_out_q <= valid_out_d;
            dropped_q   <= dropped_d;
            fv_q        <= fv_d;
        end
    end

    assign xcount_out      = x_out_q;
    assign ycount_out      = y_out_q;
    assign diameter_out    = diam_out_q;
    assign hits_out        = hits_out_q;
    assign valid_out       = valid_out_q;
    assign dropped_out     = dropped_q;
    assign frame_valid_out = fv_q;

endmodule

// File: tb/tb_target_tracker.sv
module tb_target_tracker;

    localparam int NT = 4;
    localparam int XW = 12;
    localparam int YW = 11;
    localparam int SW = 11;
    localparam int HW = 6;
    localparam int MIN_HITS = 2;

    logic                     clk_in = 1'b0;
    logic                     rst_in = 1'b0;
    logic                     det_valid_in = 1'b0;
    logic                     det_ready_out;
    logic [XW-1:0]            det_x_in = '0;
    logic [YW-1:0]            det_y_in = '0;
    logic [YW-1:0]            det_diam_in = '0;
    logic [SW-1:0]            det_score_in = '0;
    logic                     frame_end_in = 1'b0;
    logic [NT-1:0][XW-1:0]    xcount_out;
    logic [NT-1:0][YW-1:0]    ycount_out;
    logic [NT-1:0][YW-1:0]    diameter_out;
    logic [NT-1:0][HW-1:0]    hits_out;
    logic [NT-1:0]            valid_out;
    logic                     frame_valid_out;
    logic [7:0]               dropped_out;

    target_tracker #(
        .NUM_TARGETS   (NT),
        .SCREEN_WIDTH  (1280),
        .SCREEN_HEIGHT (720),
        .SCORE_W       (SW),
        .MIN_HITS      (MIN_HITS),
        .HIT_W         (HW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .det_valid_in    (det_valid_in),
        .det_ready_out   (det_ready_out),
        .det_x_in        (det_x_in),
        .det_y_in        (det_y_in),
        .det_diam_in     (det_diam_in),
        .det_score_in    (det_score_in),
        .frame_end_in    (frame_end_in),
        .xcount_out      (xcount_out),
        .ycount_out      (ycount_out),
        .diameter_out    (diameter_out),
        .hits_out        (hits_out),
        .valid_out       (valid_out),
        .frame_valid_out (frame_valid_out),
        .dropped_out     (dropped_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: the working table as plain integers.
    int m_valid [NT];
    int m_x     [NT];
    int m_y     [NT];
    int m_d     [NT];
    int m_s     [NT];
    int m_h     [NT];
    int m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) begin
            m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0; m_d[i] = 0; m_s[i] = 0; m_h[i] = 0;
        end
        m_drop = 0;
    endtask

    task automatic model_apply(input int x, input int y, input int d, input int s);
        int match, free, worst, dx, dy;
        match = -1;
        free  = -1;
        for (int i = 0; i < NT; i++) begin
            dx = x - m_x[i];
            dy = y - m_y[i];
            if (m_valid[i] != 0 && match < 0 && (dx*dx + dy*dy) <= d*d) match = i;
            if (m_valid[i] == 0 && free < 0) free = i;
        end
        if (match >= 0) begin
            m_h[match] = (m_h[match] < 63) ? m_h[match] + 1 : 63;
            if (s < m_s[match]) begin
                m_x[match] = x; m_y[match] = y; m_d[match] = d; m_s[match] = s;
            end
        end else begin
            if (free < 0) begin
                worst = 0;
                for (int i = 1; i < NT; i++) if (m_s[i] > m_s[worst]) worst = i;
                if (s < m_s[worst]) free = worst;
                else if (m_drop < 255) m_drop++;
            end
            if (free >= 0) begin
                m_valid[free] = 1; m_x[free] = x; m_y[free] = y;
                m_d[free] = d; m_s[free] = s; m_h[free] = 1;
            end
        end
    endtask

    // Drive one detection (optionally with frame_end in the handshake cycle).
    task automatic send(input int x, input int y, input int d, input int s, input bit fe);
        int n;
        det_x_in     = XW'(x);
        det_y_in     = YW'(y);
        det_diam_in  = YW'(d);
        det_score_in = SW'(s);
        det_valid_in = 1'b1;
        n = 0;
        while (!det_ready_out && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 20) chk("send_ready", {31'd0, det_ready_out}, 1);
        frame_end_in = fe;
        model_apply(x, y, d, s);
        @(negedge clk_in);
        det_valid_in = 1'b0;
        frame_end_in = 1'b0;
    endtask

    task automatic check_commit(input string tag);
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("%s_x%0d", tag, i), xcount_out[i], m_x[i]);
            chk($sformatf("%s_y%0d", tag, i), ycount_out[i], m_y[i]);
            chk($sformatf("%s_d%0d", tag, i), diameter_out[i], m_d[i]);
            chk($sformatf("%s_h%0d", tag, i), hits_out[i], m_h[i]);
            chk($sformatf("%s_v%0d", tag, i), valid_out[i],
                (m_valid[i] != 0 && m_h[i] >= MIN_HITS) ? 1 : 0);
        end
        chk({tag, "_dropped"}, dropped_out, m_drop);
        model_clear();
    endtask

    // lat counts negedges since the frame_end pulse was driven.
    task automatic wait_commit(input string tag, input int lat0, input int exp_lat);
        int lat;
        lat = lat0;
        while (!frame_valid_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        chk({tag, "_fv"}, {31'd0, frame_valid_out}, 1);
        if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
        check_commit(tag);
        @(negedge clk_in);
        chk({tag, "_fv_fall"}, {31'd0, frame_valid_out}, 0);
    endtask

    task automatic do_frame(input string tag);
        @(negedge clk_in);
        frame_end_in = 1'b1;
        @(negedge clk_in);
        frame_end_in = 1'b0;
        wait_commit(tag, 1, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cx [4];
        int cy [4];
        int acc, n, k;
        model_clear();
        #1 rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", {31'd0, det_ready_out}, 0);
        chk("rst_fv", {31'd0, frame_valid_out}, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_dropped", dropped_out, 0);
        chk("rst_x0", xcount_out[0], 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_ready", {31'd0, det_ready_out}, 1);

        // Single marker
        send(100, 50, 10, 30, 0);
        send(102, 51, 10, 20, 0);
        send(101, 52, 10, 25, 0);
        do_frame("single");
        chk("single_x0", xcount_out[0], 102);
        chk("single_h0", hits_out[0], 3);
        chk("single_vld", valid_out, 4'b0001);

        // Gating
        send(100, 50, 5, 100, 0);
        send(200, 50, 5, 100, 0);
        do_frame("gate1");
        chk("gate1_vld", valid_out, 4'b0000);
        send(100, 50, 5, 100, 0);
        send(200, 50, 5, 100, 0);
        send(100, 50, 5, 100, 0);
        send(200, 50, 5, 100, 0);
        do_frame("gate2");
        chk("gate2_vld", valid_out, 4'b0011);

        // Eviction
        send(100, 100, 5, 10, 0);
        send(400, 100, 5, 40, 0);
        send(700, 100, 5, 20, 0);
        send(1000, 100, 5, 30, 0);
        send(100, 600, 5, 35, 0);
        send(400, 600, 5, 50, 0);
        do_frame("evict");
        chk("evict_y1", ycount_out[1], 600);
        chk("evict_drop", dropped_out, 1);

        // Handshake with det_valid_in held high
        cx = '{300, 600, 300, 600};
        cy = '{300, 300, 600, 600};
        k = 0;
        acc = 0;
        det_x_in = XW'(cx[0]); det_y_in = YW'(cy[0]);
        det_diam_in = YW'(8); det_score_in = SW'($urandom_range(0, 2047));
        det_valid_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("hs_ready%0d", c), {31'd0, det_ready_out}, (c % 2 == 0) ? 1 : 0);
            if (det_ready_out) begin
                model_apply(int'(det_x_in), int'(det_y_in), int'(det_diam_in), int'(det_score_in));
                acc++;
            end else begin
                k++;
                det_x_in = XW'(cx[k % 4]); det_y_in = YW'(cy[k % 4]);
                det_score_in = SW'($urandom_range(0, 2047));
            end
            @(negedge clk_in);
        end
        det_valid_in = 1'b0;
        chk("hs_accepts", acc, 6);
        do_frame("hs");

        // Frame end in the handshake cycle
        send(500, 400, 10, 7, 1);
        wait_commit("fe_same", 1, 3);
        chk("fe_same_vld0", hits_out[0], 1);
        send(50, 50, 3, 9, 0);
        do_frame("fe_next");

        // Reset mid-frame
        send(800, 300, 6, 12, 0);
        send(801, 300, 6, 11, 0);
        rst_in = 1'b1;
        #1;
        chk("mrst_x0", xcount_out[0], 0);
        chk("mrst_h0", hits_out[0], 0);
        chk("mrst_ready", {31'd0, det_ready_out}, 0);
        chk("mrst_fv", {31'd0, frame_valid_out}, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_clear();
        @(negedge clk_in);
        send(700, 200, 6, 40, 0);
        send(702, 201, 6, 33, 0);
        do_frame("mrst_after");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 3; c++) begin
                cx[c] = $urandom_range(30, 1240);
                cy[c] = $urandom_range(30, 690);
            end
            n = $urandom_range(5, 16);
            for (int j = 0; j < n; j++) begin
                int sel;
                sel = $urandom_range(0, 3);
                if (sel == 3)
                    send($urandom_range(0, 1279), $urandom_range(0, 719),
                         $urandom_range(1, 12), $urandom_range(0, 2047), 0);
                else
                    send(cx[sel] + $urandom_range(0, 6) - 3, cy[sel] + $urandom_range(0, 6) - 3,
                         $urandom_range(4, 12), $urandom_range(0, 2047), 0);
                repeat ($urandom_range(0, 2)) @(negedge clk_in);
            end
            do_frame($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
